// File: rtl/updown_mod_counter_pkg.sv
// ============================================================================
// Module   : updown_mod_counter_pkg
// Desc     : Shared types and direction constants for updown_mod_counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package updown_mod_counter_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } cnt_mode_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

`default_nettype wire

// File: rtl/updown_mod_counter_next.sv
// ============================================================================
// Module   : updown_mod_counter_next
// Desc     : Combinational next-count, wrap-event and saturate-hit generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module updown_mod_counter_next
    import updown_mod_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 16
) (
    input  logic [WIDTH-1:0] i_cnt,
    input  logic             i_up_dn,
    input  logic             i_mode,
    output logic [WIDTH-1:0] o_nxt,
    output logic             o_wrap,
    output logic             o_sat
);

    // One extra bit keeps MOD-1 and +1 exact when MOD == 2**WIDTH
    localparam logic [WIDTH:0] c_max = (WIDTH+1)'(MOD - 1);
    localparam logic [WIDTH:0] c_one = (WIDTH+1)'(1);

    logic [WIDTH:0] w_cur;
    logic [WIDTH:0] w_nxt;
    logic           w_unused_msb;

    always_comb begin
        w_cur  = {1'b0, i_cnt};
        w_nxt  = w_cur;
        o_wrap = 1'b0;
        o_sat  = 1'b0;
        if (i_up_dn == DIR_UP) begin
            if (w_cur < c_max) begin
                w_nxt = w_cur + c_one;
            end else if (i_mode == MODE_SAT) begin
                w_nxt = c_max;
                o_sat = 1'b1;
            end else begin
                w_nxt  = '0;
                o_wrap = 1'b1;
            end
        end else begin
            if (w_cur != '0) begin
                w_nxt = w_cur - c_one;
            end else if (i_mode == MODE_SAT) begin
                w_nxt = '0;
                o_sat = 1'b1;
            end else begin
                w_nxt  = c_max;
                o_wrap = 1'b1;
            end
        end
    end

    // Result is always below MOD, so the extension bit is always zero
    assign w_unused_msb = w_nxt[WIDTH];
    assign o_nxt        = w_nxt[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/updown_mod_counter.sv
// ============================================================================
// Module   : updown_mod_counter
// Desc     : Parametrised up/down modulo counter with load, enable, wrap or
//            saturate boundary mode, terminal count and wrap-event pulse.
// Options  : UPDOWN_MOD_COUNTER_STICKY_EN adds clr_sticky / ovf_sticky.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module updown_mod_counter
    import updown_mod_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MOD     = 16,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef UPDOWN_MOD_COUNTER_STICKY_EN
    input  logic             clr_sticky,
    output logic             ovf_sticky,
`endif
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH:0]   c_mod = (WIDTH+1)'(MOD);
    localparam logic [WIDTH-1:0] c_max = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] c_rst = WIDTH'(RST_VAL);

    generate
        if (MOD < 2 || MOD > 2**WIDTH || RST_VAL < 0 || RST_VAL >= MOD) begin : g_bad_params
            $error("updown_mod_counter: illegal MOD/RST_VAL for given WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] r_out;
    logic             r_wrap;
    logic [WIDTH-1:0] w_nxt;
    logic             w_wrap_hit;
    logic             w_sat_hit;
    logic [WIDTH-1:0] w_load_val;

    updown_mod_counter_next #(
        .WIDTH (WIDTH),
        .MOD   (MOD)
    ) u_next (
        .i_cnt   (r_out),
        .i_up_dn (up_dn),
        .i_mode  (mode),
        .o_nxt   (w_nxt),
        .o_wrap  (w_wrap_hit),
        .o_sat   (w_sat_hit)
    );

    assign w_load_val = ({1'b0, load_val} >= c_mod) ? c_max : load_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out  <= c_rst;
            r_wrap <= 1'b0;
        end else if (load) begin
            r_out  <= w_load_val;
            r_wrap <= 1'b0;
        end else if (en) begin
            r_out  <= w_nxt;
            r_wrap <= w_wrap_hit;
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign out  = r_out;
    assign wrap = r_wrap;
    assign tc   = en & ((up_dn & (r_out == c_max)) | (~up_dn & (r_out == '0)));

`ifdef UPDOWN_MOD_COUNTER_STICKY_EN
    logic r_ovf_sticky;
    logic w_sticky_set;

    // Set has priority over clear so a same-edge event is never lost
    assign w_sticky_set = ~load & en & (w_wrap_hit | w_sat_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf_sticky <= 1'b0;
        end else if (w_sticky_set) begin
            r_ovf_sticky <= 1'b1;
        end else if (clr_sticky) begin
            r_ovf_sticky <= 1'b0;
        end
    end

    assign ovf_sticky = r_ovf_sticky;
`else
    logic w_unused_sat;
    assign w_unused_sat = w_sat_hit;
`endif

endmodule

`default_nettype wire

// File: tb/tb_updown_mod_counter.sv
// ============================================================================
// Module   : tb_updown_mod_counter
// Desc     : Directed scoreboard bench for updown_mod_counter with WIDTH=4,
//            a modulus of 10 and RST_VAL=3; covers the sticky overflow option.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_updown_mod_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up_dn;
    logic       mode;
    logic       load;
    logic [3:0] load_val;
    logic       clr_sticky;
    logic [3:0] out;
    logic       tc;
    logic       wrap;
`ifdef UPDOWN_MOD_COUNTER_STICKY_EN
    logic       ovf_sticky;
`endif

    typedef struct packed {
        logic [3:0] out;
        logic       wrap;
        logic       sticky;
    } exp_t;

    exp_t q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   m_out;
    logic m_wrap;
    logic m_sticky;

    always #5 clk = ~clk;

    updown_mod_counter #(
        .WIDTH   (4),
        .MOD     (10),
        .RST_VAL (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .up_dn      (up_dn),
        .mode       (mode),
        .load       (load),
        .load_val   (load_val),
`ifdef UPDOWN_MOD_COUNTER_STICKY_EN
        .clr_sticky (clr_sticky),
        .ovf_sticky (ovf_sticky),
`endif
        .out        (out),
        .tc         (tc),
        .wrap       (wrap)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, predict the post-edge state, then check it
    task automatic step(input logic e, input logic u, input logic m, input logic l,
                        input logic [3:0] lv, input logic c);
        logic b;
        exp_t x;
        @(negedge clk);
        en = e; up_dn = u; mode = m; load = l; load_val = lv; clr_sticky = c;
        #1;
        b = (u && m_out == 9) || (!u && m_out == 0);
        chk("tc", {31'd0, tc}, {31'd0, e & b});
        if (l) begin
            m_out  = (lv >= 4'd10) ? 9 : int'(lv);
            m_wrap = 1'b0;
        end else if (e) begin
            if (b && m) begin
                m_wrap = 1'b0;
            end else if (b) begin
                m_out  = u ? 0 : 9;
                m_wrap = 1'b1;
            end else begin
                m_out  = u ? m_out + 1 : m_out - 1;
                m_wrap = 1'b0;
            end
        end else begin
            m_wrap = 1'b0;
        end
        if (!l && e && b) m_sticky = 1'b1;
        else if (c)       m_sticky = 1'b0;
        q.push_back('{out: 4'(m_out), wrap: m_wrap, sticky: m_sticky});
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            x = q.pop_front();
            chk("out", {28'd0, out}, {28'd0, x.out});
            chk("wrap", {31'd0, wrap}, {31'd0, x.wrap});
`ifdef UPDOWN_MOD_COUNTER_STICKY_EN
            chk("ovf_sticky", {31'd0, ovf_sticky}, {31'd0, x.sticky});
`endif
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; up_dn = 1'b1; mode = 1'b0; load = 1'b0;
        load_val = 4'd0; clr_sticky = 1'b0;
        m_out = 3; m_wrap = 1'b0; m_sticky = 1'b0;

        @(negedge clk);
        chk("reset_out", {28'd0, out}, 32'd3);
        chk("reset_wrap", {31'd0, wrap}, 32'd0);
`ifdef UPDOWN_MOD_COUNTER_STICKY_EN
        chk("reset_sticky", {31'd0, ovf_sticky}, 32'd0);
`endif
        rst = 1'b0;

        // Up, wrap mode: 4..9,0,1
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("up_end", {28'd0, out}, 32'd1);

        // Down, wrap mode: 0,9,8
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("down_end", {28'd0, out}, 32'd8);

        // Up, saturate mode from 8: 9,9,9,9
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("sat_end", {28'd0, out}, 32'd9);
`ifdef UPDOWN_MOD_COUNTER_STICKY_EN
        chk("sat_sticky", {31'd0, ovf_sticky}, 32'd1);
`endif

        // Load clamps, overrides a pending wrap, then plain load and hold
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'd13, 1'b0);
        chk("load_clamp", {28'd0, out}, 32'd9);
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);

        // Down, saturate mode at 0
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

        // Count to 7, then asynchronous reset between edges
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("pre_rst_out", {28'd0, out}, 32'd7);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst_out", {28'd0, out}, 32'd3);
        chk("async_rst_wrap", {31'd0, wrap}, 32'd0);
`ifdef UPDOWN_MOD_COUNTER_STICKY_EN
        chk("async_rst_sticky", {31'd0, ovf_sticky}, 32'd0);
`endif
        @(posedge clk);
        #1;
        chk("rst_held_out", {28'd0, out}, 32'd3);
        @(negedge clk);
        rst = 1'b0; en = 1'b0;
        m_out = 3; m_wrap = 1'b0; m_sticky = 1'b0;
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("resume_out", {28'd0, out}, 32'd5);

        // Wrap with simultaneous clear (set wins), then clear alone
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'd9, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        chk("wrap_clr_wrap", {31'd0, wrap}, 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
